// File: rtl/dwt_level_sched_pkg.sv
// Shared types and defaults for the DWT level scheduler.
// The optional watchdog is enabled with the DWT_SCHED_TIMEOUT_EN macro.
package dwt_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        LAUNCH,
        WAIT,
        GAP,
        FIN
    } state_e;

    localparam logic SRC_BUF = 1'b0;
    localparam logic SRC_LL  = 1'b1;

    localparam int DEF_W_WIDTH    = 8;
    localparam int DEF_MAX_LEVELS = 5;
    localparam int DEF_W_LVL      = 3;

endpackage

// File: rtl/dwt_level_sched_if.sv
// Tile-controller and lifting-core signals of the DWT level scheduler.
// The master modport is the scheduler's view; the slave modport is its environment's view.
interface dwt_level_sched_if
    import dwt_sched_pkg::*;
#(
    parameter int W_WIDTH = DEF_W_WIDTH,
    parameter int W_LVL   = DEF_W_LVL
);

    logic               start;
    logic [W_WIDTH-1:0] width;
    logic [W_LVL-1:0]   ndecomp;
    logic               core_ready;
    logic               core_go;
    logic [W_WIDTH-1:0] core_width;
    logic [W_LVL-1:0]   core_level;
    logic               src_sel;
    logic               busy;
    logic               done;
    logic               err;
    logic               timeout;

    modport master (
        input  start, width, ndecomp, core_ready,
        output core_go, core_width, core_level, src_sel, busy, done, err, timeout
    );

    modport slave (
        output start, width, ndecomp, core_ready,
        input  core_go, core_width, core_level, src_sel, busy, done, err, timeout
    );

endinterface

// File: rtl/dwt_level_sched_wdog.sv
// Per-level watchdog for the DWT scheduler: counts WAIT cycles until core_ready.
// Instantiated only when DWT_SCHED_TIMEOUT_EN is defined.
module dwt_sched_wdog #(
    parameter int LIMIT = 4096
) (
    input  logic clk,
    input  logic rstn,
    input  logic active,
    input  logic ready,
    output logic expired
);

    localparam int CW = $clog2(LIMIT) + 1;

    logic [CW-1:0] cnt_q, cnt_d;

    // The count is 0 in the core_go cycle, so expiry lands LIMIT cycles after go.
    always_comb begin
        cnt_d   = (active && !ready) ? cnt_q + 1'b1 : '0;
        expired = active && !ready && (cnt_q == CW'(LIMIT - 1));
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dwt_level_sched.sv
// Sequences the 5/3 lifting core across the decomposition levels of one tile.
// Define DWT_SCHED_TIMEOUT_EN to add the per-level watchdog and the sticky timeout flag.
module dwt_level_sched
    import dwt_sched_pkg::*;
#(
    parameter int W_WIDTH    = DEF_W_WIDTH,
    parameter int MAX_LEVELS = DEF_MAX_LEVELS,
    parameter int W_LVL      = DEF_W_LVL
`ifdef DWT_SCHED_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 4096
`endif
) (
    input  logic              clk,
    input  logic              rstn,
    dwt_level_sched_if.master sched
);

    state_e             state_q, state_d;
    logic [W_WIDTH-1:0] width_q, width_d;
    logic [W_LVL-1:0]   ndecomp_q, ndecomp_d;
    logic [W_LVL-1:0]   level_q, level_d;
    logic [W_WIDTH-1:0] core_width_q, core_width_d;
    logic               src_sel_q, src_sel_d;
    logic               core_go_q, core_go_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic [W_LVL-1:0]   level_next;
    logic               more_levels;
    logic               wdog_expired;

    // Every level width (w >> l, l < nd) must be even and at least 2.
    function automatic logic cfg_ok(input logic [W_WIDTH-1:0] w, input logic [W_LVL-1:0] nd);
        logic               ok;
        logic [W_WIDTH-1:0] lw;
        ok = (nd != '0) && (int'(nd) <= MAX_LEVELS);
        for (int l = 0; l < MAX_LEVELS; l++) begin
            lw = w >> l;
            if ((l < int'(nd)) && (lw[0] || (lw < W_WIDTH'(2)))) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

    assign level_next  = (level_q == W_LVL'(MAX_LEVELS - 1)) ? level_q : level_q + 1'b1;
    assign more_levels = ({1'b0, level_q} + 1'b1) < {1'b0, ndecomp_q};

    // NOTE: every _d gets its default first, so no path through the case infers a latch.
    always_comb begin
        state_d      = state_q;
        width_d      = width_q;
        ndecomp_d    = ndecomp_q;
        level_d      = level_q;
        core_width_d = core_width_q;
        src_sel_d    = src_sel_q;
        busy_d       = busy_q;
        core_go_d    = 1'b0;
        done_d       = 1'b0;
        err_d        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (sched.start) begin
                    width_d   = sched.width;
                    ndecomp_d = sched.ndecomp;
                    busy_d    = cfg_ok(sched.width, sched.ndecomp);
                    state_d   = CHECK;
                end
            end
            // busy_q already carries the verdict, so a rejected start never shows busy.
            CHECK: begin
                if (busy_q) begin
                    level_d      = '0;
                    core_width_d = width_q;
                    src_sel_d    = SRC_BUF;
                    state_d      = LAUNCH;
                end else begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            LAUNCH: begin
                core_go_d = 1'b1;
                state_d   = WAIT;
            end
            WAIT: begin
                if (sched.core_ready) begin
                    if (more_levels) begin
                        state_d = GAP;
                    end else begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = FIN;
                    end
                end else if (wdog_expired) begin
                    state_d = FIN;
                end
            end
            // Buffer turnaround; the next level's go is issued straight from here.
            GAP: begin
                level_d      = level_next;
                core_width_d = width_q >> level_next;
                src_sel_d    = SRC_LL;
                core_go_d    = 1'b1;
                state_d      = WAIT;
            end
            FIN: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: registers take <= only; a blocking write here would race with readers of the _q values.
    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q      <= IDLE;
            width_q      <= '0;
            ndecomp_q    <= '0;
            level_q      <= '0;
            core_width_q <= '0;
            src_sel_q    <= SRC_BUF;
            core_go_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            width_q      <= width_d;
            ndecomp_q    <= ndecomp_d;
            level_q      <= level_d;
            core_width_q <= core_width_d;
            src_sel_q    <= src_sel_d;
            core_go_q    <= core_go_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

`ifdef DWT_SCHED_TIMEOUT_EN
    logic timeout_q, timeout_d;

    dwt_sched_wdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk     (clk),
        .rstn    (rstn),
        .active  (state_q == WAIT),
        .ready   (sched.core_ready),
        .expired (wdog_expired)
    );

    always_comb begin
        timeout_d = timeout_q;
        if ((state_q == IDLE) && sched.start) begin
            timeout_d = 1'b0;
        end else if (wdog_expired) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end

    assign sched.timeout = timeout_q;
`else
    assign wdog_expired  = 1'b0;
    assign sched.timeout = 1'b0;
`endif

    assign sched.core_go    = core_go_q;
    assign sched.core_width = core_width_q;
    assign sched.core_level = level_q;
    assign sched.src_sel    = src_sel_q;
    assign sched.busy       = busy_q;
    assign sched.done       = done_q;
    assign sched.err        = err_q;

endmodule

// File: tb/tb_dwt_level_sched.sv
// Directed bench for dwt_level_sched: a scoreboard of expected core launches is popped on each core_go.
// The timeout scenario runs only when DWT_SCHED_TIMEOUT_EN is defined.
module tb_dwt_level_sched;
    import dwt_sched_pkg::*;

    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    dwt_level_sched_if #(.W_WIDTH(8), .W_LVL(3)) sif ();

    dwt_level_sched #(
        .W_WIDTH    (8),
        .MAX_LEVELS (5),
        .W_LVL      (3)
`ifdef DWT_SCHED_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (64)
`endif
    ) dut (
        .clk   (clk),
        .rstn  (rstn),
        .sched (sif)
    );

    typedef struct packed {
        logic [7:0] width;
        logic [2:0] level;
        logic       src;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   go_cnt       = 0;
    int   done_cnt     = 0;
    int   err_cnt      = 0;
    int   g0, d0, e0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected launches for one accepted tile.
    task automatic push_levels(input logic [7:0] w, input logic [2:0] nd);
        exp_t e;
        for (int l = 0; l < int'(nd); l++) begin
            e.width = w >> l;
            e.level = 3'(l);
            e.src   = (l == 0) ? SRC_BUF : SRC_LL;
            exp_q.push_back(e);
        end
    endtask

    // Ends in the first core_go cycle when the start is accepted.
    task automatic start_run(input logic [7:0] w, input logic [2:0] nd, input logic accept);
        sif.width   = w;
        sif.ndecomp = nd;
        sif.start   = 1'b1;
        if (accept) push_levels(w, nd);
        tick();
        sif.start = 1'b0;
        check("busy_n1", 32'(sif.busy), 32'(accept));
        check("err_n1", 32'(sif.err), 32'd0);
        tick();
        check("err_n2", 32'(sif.err), 32'(!accept));
        check("go_n2", 32'(sif.core_go), 32'd0);
        tick();
        check("go_n3", 32'(sif.core_go), 32'(accept));
        check("busy_n3", 32'(sif.busy), 32'(accept));
        check("err_n3", 32'(sif.err), 32'd0);
    endtask

    // Called in a go cycle; ends in the next go cycle (or two cycles after the final ready).
    task automatic finish_level(input int delay, input logic last);
        for (int i = 0; i < delay; i++) tick();
        check("busy_wait", 32'(sif.busy), 32'd1);
        sif.core_ready = 1'b1;
        tick();
        sif.core_ready = 1'b0;
        check("done_m1", 32'(sif.done), 32'(last));
        check("busy_m1", 32'(sif.busy), 32'(!last));
        check("go_m1", 32'(sif.core_go), 32'd0);
        tick();
        check("go_m2", 32'(sif.core_go), 32'(!last));
        check("done_m2", 32'(sif.done), 32'd0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sif.core_go === 1'b1) begin
            go_cnt++;
            check("go_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("go_width", 32'(sif.core_width), 32'(e.width));
                check("go_level", 32'(sif.core_level), 32'(e.level));
                check("go_src", 32'(sif.src_sel), 32'(e.src));
            end
        end
        if (sif.done === 1'b1) done_cnt++;
        if (sif.err === 1'b1) err_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL tb_watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [7:0] rej_w[3];
        logic [2:0] rej_n[3];
        rej_w = '{8'd16, 8'd12, 8'd16};
        rej_n = '{3'd0, 3'd3, 3'd6};

        rstn           = 1'b1;
        sif.start      = 1'b0;
        sif.width      = '0;
        sif.ndecomp    = '0;
        sif.core_ready = 1'b0;

        // Reset state
        tick();
        tick();
        rstn = 1'b0;
        check("reset_outs", 32'({sif.core_go, sif.core_width, sif.core_level, sif.src_sel,
                                  sif.busy, sif.done, sif.err, sif.timeout}), 32'd0);

        // Single level, long core latency
        d0 = done_cnt;
        start_run(8'd16, 3'd1, 1'b1);
        for (int i = 0; i < 39; i++) tick();
        check("hold_width", 32'(sif.core_width), 32'd16);
        finish_level(1, 1'b1);
        check("t1_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("t1_queue", 32'(exp_q.size()), 32'd0);

        // Stray core_ready while idle is ignored
        sif.core_ready = 1'b1;
        tick();
        sif.core_ready = 1'b0;
        check("stray_busy", 32'(sif.busy), 32'd0);
        tick();
        check("stray_go", 32'({sif.core_go, sif.done}), 32'd0);

        // Three levels; a start during level 1 is ignored
        g0 = go_cnt;
        d0 = done_cnt;
        start_run(8'd16, 3'd3, 1'b1);
        finish_level(5, 1'b0);
        sif.width   = 8'd32;
        sif.ndecomp = 3'd2;
        sif.start   = 1'b1;
        tick();
        sif.start = 1'b0;
        check("busy_start", 32'(sif.busy), 32'd1);
        check("lvl_start", 32'(sif.core_level), 32'd1);
        finish_level(3, 1'b0);
        finish_level(2, 1'b1);
        check("t2_go_cnt", 32'(go_cnt - g0), 32'd3);
        check("t2_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("t2_queue", 32'(exp_q.size()), 32'd0);

        // Rejected configurations
        g0 = go_cnt;
        e0 = err_cnt;
        for (int i = 0; i < 3; i++) begin
            start_run(rej_w[i], rej_n[i], 1'b0);
        end
        check("rej_err_cnt", 32'(err_cnt - e0), 32'd3);
        check("rej_go_cnt", 32'(go_cnt - g0), 32'd0);

        // Maximum depth, zero-length final level
        d0 = done_cnt;
        start_run(8'd32, 3'd5, 1'b1);
        for (int l = 0; l < 4; l++) finish_level(1, 1'b0);
        finish_level(0, 1'b1);
        check("max_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("max_queue", 32'(exp_q.size()), 32'd0);

        // Reset while waiting on level 1
        d0 = done_cnt;
        start_run(8'd16, 3'd3, 1'b1);
        finish_level(2, 1'b0);
        tick();
        tick();
        rstn = 1'b1;
        exp_q.delete();
        tick();
        rstn = 1'b0;
        check("rst_mid_outs", 32'({sif.core_go, sif.core_width, sif.core_level, sif.src_sel,
                                    sif.busy, sif.done, sif.err, sif.timeout}), 32'd0);
        for (int i = 0; i < 4; i++) tick();
        check("rst_mid_done", 32'(done_cnt - d0), 32'd0);
        check("rst_mid_busy", 32'(sif.busy), 32'd0);
        start_run(8'd8, 3'd2, 1'b1);
        finish_level(0, 1'b0);
        finish_level(4, 1'b1);
        check("rst_fresh_done", 32'(done_cnt - d0), 32'd1);
        check("rst_fresh_queue", 32'(exp_q.size()), 32'd0);

`ifdef DWT_SCHED_TIMEOUT_EN
        // Watchdog: core_ready withheld
        d0 = done_cnt;
        start_run(8'd16, 3'd1, 1'b1);
        for (int i = 0; i < 63; i++) tick();
        check("to_before", 32'(sif.timeout), 32'd0);
        tick();
        check("to_set", 32'(sif.timeout), 32'd1);
        check("to_busy_hold", 32'(sif.busy), 32'd1);
        tick();
        check("to_busy_drop", 32'(sif.busy), 32'd0);
        check("to_sticky", 32'(sif.timeout), 32'd1);
        for (int i = 0; i < 3; i++) tick();
        check("to_no_done", 32'(done_cnt - d0), 32'd0);
        start_run(8'd8, 3'd1, 1'b1);
        check("to_cleared", 32'(sif.timeout), 32'd0);
        finish_level(1, 1'b1);
        check("to_queue", 32'(exp_q.size()), 32'd0);
`else
        check("timeout_tied", 32'(sif.timeout), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
